aes_encipher_block: RTL and testbench
=====================================

// Module: aes_encipher_block
// PURPOSE
//   Iterative AES encipher datapath. It is the forward counterpart of the decipher round logic.
//   It holds one 128-bit state and runs InitRound, Nr-1 main rounds and a final round under an FSM.
//   Round keys come from the key memory through round. SubBytes uses the key memory's shared
//   4-byte S-box port, one word per cycle. Sits beside the decipher datapath under the AES core.
// PARAMETERS
//   AES128_ROUNDS   10   rounds used when keylen=0 (localparam)
//   AES256_ROUNDS   14   rounds used when keylen=1 (localparam)
// PORTS
//   clk        in   1    system clock; all state updates on rising edge
//   reset_n    in   1    asynchronous, active-low reset
//   next       in   1    start pulse; accepted only when ready=1
//   keylen     in   1    0: AES-128, 1: AES-256; sampled when next is accepted
//   round      out  4    round key index requested from key memory
//   round_key  in   128  key for index round, valid combinationally in the same cycle
//   sboxw      out  32   word sent to the shared forward S-box
//   new_sboxw  in   32   S-box output for sboxw, combinational, 4 parallel byte lookups
//   block      in   128  plaintext; captured in the INIT cycle
//   new_block  out  128  ciphertext; valid while ready=1
//   ready      out  1    1 = idle and result valid; 0 = busy
// BEHAVIOUR
// - Reset (async, reset_n=0)
//   - ready=1, new_block=0, round=0, sboxw=0; FSM goes to IDLE; word counter 0; round counter 0.
// - FSM states: IDLE, INIT, SBOX, MAIN.
//   - IDLE: ready=1. next=1 latches keylen; go to INIT and drop ready at that edge. Nr = 10 or 14.
//   - INIT (1 cycle): round=0. state <= block ^ round_key. Round counter <= 1. Go to SBOX.
//   - SBOX (4 cycles, word w=0..3)
//     - sboxw = state[127-32w -: 32].
//     - state word w <= new_sboxw.
//     - After w=3, go to MAIN.
//   - MAIN (1 cycle): round = round counter.
//     - If counter < Nr: state <= MixColumns(ShiftRows(state)) ^ round_key; counter+1; go to SBOX.
//     - If counter = Nr: state <= ShiftRows(state) ^ round_key; go to IDLE; ready=1 next cycle.
// - State layout
//   - Bytes are column-major: column c = state[127-32c -: 32], row 0 in the MSB of each column.
//   - ShiftRows rotates row r left by r columns.
//   - MixColumns uses the {02,03,01,01} circulant over GF(2^8) with polynomial 0x11b.
// - Latency
//   - ready is low for exactly 1 + 5*Nr cycles: 51 cycles (AES-128), 71 cycles (AES-256).
//   - The edge that accepts next is cycle 0. ready is back to 1 after cycle 51 or 71.
// - new_block is the state register.
//   - It is meaningful only while ready=1 and holds until the next accepted next.
// - next=1 while ready=0 is ignored; the operation in flight is unaffected.
// - keylen and block changes while busy have no effect. keylen is latched; block is read only in INIT.
// - next held high: a new operation starts on the first cycle ready=1 (back-to-back allowed).
// - round and sboxw are registered-state-derived; there is no combinational path from next.
//   - round=0 in IDLE and INIT. sboxw=0 outside SBOX.
// - Reset mid-operation: immediate abort. Outputs return to reset values; no partial result retained.
// - round wraps never: counter max is 14 and fits in 4 bits.
// TESTING
// - FIPS-197 C.1, key 000102..0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
//   - The bench key-memory model serves round keys and the S-box.
// - FIPS-197 C.3, keylen=1, key 000102..1f, same pt -> 8ea2b7ca516745bfeafc49904b496089.
// - Latency/handshake: count ready=0 cycles. Require 51 (AES-128) and 71 (AES-256).
//   - round sequence 0,1..Nr must appear in order.
// - next pulsed and block/keylen toggled at cycles 10 and 30 of a run -> result and latency unchanged.
// - reset_n=0 at cycle 20 of a run -> ready=1, new_block=0 immediately.
//   - A following C.1 run gives the correct result.
// - next held high for 3 ops with changing block -> 3 correct ciphertexts, 1 idle cycle between runs.

Source files
------------

// File: rtl/aes_encipher_block.sv
// Iterative AES encipher datapath: one 128-bit state register stepped through
// InitRound, Nr-1 full rounds and a final round, with SubBytes one word per cycle.
module aes_encipher_block (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  localparam int AES128_ROUNDS = 10;
  localparam int AES256_ROUNDS = 14;

  typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

  state_t       state_q, state_d;
  logic [127:0] data_q, data_d;
  logic [1:0]   word_q, word_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         keylen_q, keylen_d;
  logic [3:0]   num_rounds;

  function automatic logic [7:0] gm2(input logic [7:0] b);
    gm2 = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] b);
    gm3 = gm2(b) ^ b;
  endfunction

  // Byte (row r, column c) lives at bits 127-32c-8r; row r moves left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-32*c-8*r -: 8] = s[127-32*((c+r)%4)-8*r -: 8];
      end
    end
    shift_rows = o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   b0, b1, b2, b3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      b0 = s[127-32*c -: 8];
      b1 = s[119-32*c -: 8];
      b2 = s[111-32*c -: 8];
      b3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gm2(b0) ^ gm3(b1) ^ b2 ^ b3;
      o[119-32*c -: 8] = b0 ^ gm2(b1) ^ gm3(b2) ^ b3;
      o[111-32*c -: 8] = b0 ^ b1 ^ gm2(b2) ^ gm3(b3);
      o[103-32*c -: 8] = gm3(b0) ^ b1 ^ b2 ^ gm2(b3);
    end
    mix_columns = o;
  endfunction

  assign num_rounds = keylen_q ? 4'(AES256_ROUNDS) : 4'(AES128_ROUNDS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      word_q   <= 2'd0;
      rnd_q    <= 4'd0;
      keylen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      word_q   <= word_d;
      rnd_q    <= rnd_d;
      keylen_q <= keylen_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    word_d   = word_q;
    rnd_d    = rnd_q;
    keylen_d = keylen_q;
    case (state_q)
      IDLE: begin
        if (next) begin
          keylen_d = keylen;
          state_d  = INIT;
        end
      end
      INIT: begin
        data_d  = block ^ round_key;
        rnd_d   = 4'd1;
        word_d  = 2'd0;
        state_d = SBOX;
      end
      SBOX: begin
        case (word_q)
          2'd0:    data_d[127:96] = new_sboxw;
          2'd1:    data_d[95:64]  = new_sboxw;
          2'd2:    data_d[63:32]  = new_sboxw;
          default: data_d[31:0]   = new_sboxw;
        endcase
        word_d = word_q + 2'd1;
        if (word_q == 2'd3) state_d = MAIN;
      end
      MAIN: begin
        // The last round skips MixColumns and returns to IDLE.
        if (rnd_q < num_rounds) begin
          data_d  = mix_columns(shift_rows(data_q)) ^ round_key;
          rnd_d   = rnd_q + 4'd1;
          state_d = SBOX;
        end else begin
          data_d  = shift_rows(data_q) ^ round_key;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == IDLE);
    round = (state_q == MAIN) ? rnd_q : 4'd0;
    sboxw = 32'd0;
    if (state_q == SBOX) begin
      case (word_q)
        2'd0:    sboxw = data_q[127:96];
        2'd1:    sboxw = data_q[95:64];
        2'd2:    sboxw = data_q[63:32];
        default: sboxw = data_q[31:0];
      endcase
    end
  end

  assign new_block = data_q;

endmodule

// File: tb/tb_aes_encipher_block.sv
// Bench for aes_encipher_block: a key-memory model serves round keys and the S-box;
// known-answer vectors plus latency, disturbance, reset-abort and back-to-back runs.
module tb_aes_encipher_block;

  typedef struct {
    string          name;
    logic           keylen;
    logic [255:0]   key;
    logic [127:0]   pt;
    logic [127:0]   ct;
  } vec_t;

  logic         clk;
  logic         reset_n;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  logic [7:0]   sbox_tab [0:255];
  logic [127:0] rk [0:15];
  logic [127:0] exp_q [$];
  int           n_checks;
  int           n_pass;

  aes_encipher_block dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .next      (next),
    .keylen    (keylen),
    .round     (round),
    .round_key (round_key),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw),
    .block     (block),
    .new_block (new_block),
    .ready     (ready)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // key memory model
  always_comb begin
    round_key = rk[round];
    new_sboxw = {sbox_tab[sboxw[31:24]], sbox_tab[sboxw[23:16]],
                 sbox_tab[sboxw[15:8]],  sbox_tab[sboxw[7:0]]};
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    gmul = p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    rotl8 = (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] y;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int k = 1; k < 256; k++) begin
        y = 8'(k);
        if (gmul(8'(x), y) == 8'h01) inv = y;
      end
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // FIPS-197 key expansion into rk[0..Nr]
  task automatic load_key(input logic [255:0] key, input logic kl);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = kl ? 8 : 4;
    nr = kl ? 14 : 10;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         rk[r] = '0;
    end
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic sb_check(input string name);
    logic [127:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, new_block, e);
    end
  endtask

  // driver: present one operation and return at the negedge after acceptance
  task automatic start_op(input vec_t v);
    load_key(v.key, v.keylen);
    @(negedge clk);
    block  = v.pt;
    keylen = v.keylen;
    next   = 1'b1;
    exp_q.push_back(v.ct);
    @(posedge clk);
    @(negedge clk);
    next = 1'b0;
  endtask

  // count busy cycles, trace round order, optionally disturb inputs, then score
  task automatic wait_done(input vec_t v, input int disturb);
    int busy, exp_r, nr;
    logic ok_r;
    nr    = v.keylen ? 14 : 10;
    busy  = 0;
    exp_r = 1;
    ok_r  = 1'b1;
    while (ready == 1'b0 && busy < 200) begin
      if (busy == 0 && round != 4'd0) ok_r = 1'b0;
      if (round != 4'd0) begin
        if (int'(round) != exp_r) ok_r = 1'b0;
        exp_r++;
      end
      if (disturb != 0) begin
        if (busy == 10) begin
          next = 1'b1; block = ~block; keylen = ~keylen;
        end else if (busy == 30) begin
          next = 1'b1; block = 128'h0; keylen = ~keylen;
        end else begin
          next = 1'b0;
        end
      end
      busy++;
      @(negedge clk);
    end
    next = 1'b0;
    check({v.name, " latency"}, 128'(busy), 128'(1 + 5 * nr));
    check({v.name, " round order"}, 128'({ok_r, exp_r == nr + 1}), 128'(2'b11));
    sb_check({v.name, " ciphertext"});
  endtask

  initial begin
    vec_t vecs [5];
    vec_t c1;
    vec_t b2b [3];
    int   busy;

    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    next     = 1'b0;
    keylen   = 1'b0;
    block    = '0;
    build_sbox();
    for (int r = 0; r < 16; r++) rk[r] = '0;

    vecs[0] = '{"c1_aes128", 1'b0,
                {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{"c3_aes256", 1'b1,
                256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089};
    vecs[2] = '{"appb_aes128", 1'b0,
                {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[3] = '{"ecb128_v1", 1'b0,
                {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h6bc1bee22e409f96e93d7e117393172a, 128'h3ad77bb40d7a3660a89ecaf32466ef97};
    vecs[4] = '{"ecb256_v1", 1'b1,
                256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                128'h6bc1bee22e409f96e93d7e117393172a, 128'hf3eed1bdb5d2a03c064b5a7e3db181f8};
    b2b[0] = '{"b2b_0", 1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
               128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'hf5d3d58503b9699de785895a96fdbaaf};
    b2b[1] = '{"b2b_1", 1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
               128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'h43b1cd7f598ece23881b00e3ed030688};
    b2b[2] = '{"b2b_2", 1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
               128'hf69f2445df4f9b17ad2b417be66c3710, 128'h7b0c785e27e8ad3f8223207104725dd4};
    c1 = vecs[0];

    // reset values
    #1;
    check("reset ready", 128'(ready), 128'(1));
    check("reset new_block", new_block, 128'h0);
    check("reset round", 128'(round), 128'h0);
    check("reset sboxw", 128'(sboxw), 128'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // known-answer table
    for (int i = 0; i < 5; i++) begin
      start_op(vecs[i]);
      wait_done(vecs[i], 0);
    end

    // next / block / keylen disturbed mid-run
    c1.name = "c1_disturbed";
    start_op(c1);
    wait_done(c1, 1);
    keylen = 1'b0;

    // asynchronous reset in the middle of a run
    start_op(vecs[0]);
    repeat (19) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort ready", 128'(ready), 128'(1));
    check("abort new_block", new_block, 128'h0);
    void'(exp_q.pop_front());
    @(negedge clk);
    reset_n = 1'b1;
    c1.name = "c1_after_abort";
    start_op(c1);
    wait_done(c1, 0);

    // next held high: back-to-back runs with one idle cycle between them
    load_key(b2b[0].key, 1'b0);
    @(negedge clk);
    keylen = 1'b0;
    block  = b2b[0].pt;
    next   = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(b2b[k].ct);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k > 0) check({b2b[k].name, " one idle cycle"}, 128'(ready), 128'(0));
      busy = 0;
      while (ready == 1'b0 && busy < 200) begin
        busy++;
        @(negedge clk);
      end
      check({b2b[k].name, " latency"}, 128'(busy), 128'(51));
      sb_check({b2b[k].name, " ciphertext"});
      if (k < 2) block = b2b[k+1].pt;
      else       next = 1'b0;
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
